// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: bus handshake structs,
// bus tracking states and default MDU latencies.
package hazard_pkg;

    localparam int DEF_MUL_LAT = 3;
    localparam int DEF_DIV_LAT = 32;
    localparam int MDU_CNT_W   = 6;

    typedef enum logic [1:0] {I_IDLE, I_WAIT, I_DROP} ibus_state_t;
    typedef enum logic [1:0] {D_IDLE, D_ADDR, D_DATA} dbus_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    // $0 is hardwired, so a write to it never feeds a consumer.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority forwarding mux for one source operand; producer 0 is the youngest
// and wins over all older producers.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 3
) (
    input  logic [4:0]                 i_src,
    input  logic [NUM_SRC-1:0]         i_en,
    input  logic [NUM_SRC-1:0][4:0]    i_dst,
    input  logic [NUM_SRC-1:0][31:0]   i_res,
    input  logic [31:0]                i_reg,
    output logic [31:0]                o_fwd
);

    // NOTE: o_fwd gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_fwd = i_reg;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (i_en[k] && reg_hit(i_dst[k], i_src)) begin
                o_fwd = i_res[k];
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, stall/bubble generation and
// ibus/dbus/MDU tracking. Define HAZARD_MDU_EN to include the MDU busy counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_RD  = 2,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  ibus_req_t                ireq,
    input  ibus_resp_t               iresp,
    input  dbus_req_t                dreq,
    input  dbus_resp_t               dresp,
    input  logic                     redirect,
    input  logic [NUM_RD-1:0][4:0]   srcD,
    input  logic [NUM_RD-1:0][4:0]   srcE,
    input  logic [NUM_RD-1:0]        useD,
    input  logic [NUM_RD-1:0][31:0]  vD,
    input  logic [NUM_RD-1:0][31:0]  vE,
    input  logic [4:0]               dstE,
    input  logic [4:0]               dstM,
    input  logic [4:0]               dstW,
    input  logic                     weE,
    input  logic                     weM,
    input  logic                     weW,
    input  logic                     loadE,
    input  logic                     loadM,
    input  logic [31:0]              resE,
    input  logic [31:0]              resM,
    input  logic [31:0]              resW,
    input  logic                     hiloD,
    input  logic                     mdu_start,
    input  logic                     mdu_div,
    output logic [NUM_RD-1:0][31:0]  fwdD,
    output logic [NUM_RD-1:0][31:0]  fwdE,
    output logic                     stall_f,
    output logic                     stall_d,
    output logic                     stall_e,
    output logic                     stall_m,
    output logic                     bubble_e,
    output logic                     bubble_w,
    output logic                     drop_i
);

    ibus_state_t r_istate;
    dbus_state_t r_dstate;
    logic        w_hilo_stall;
    logic        w_data_haz;
    logic        w_mem_wait;
    logic        w_fetch_wait;
    logic        w_unused_bus;

    assign w_unused_bus = &{1'b0, ireq.addr, iresp.addr_ok, iresp.data,
                            dreq.addr, dreq.strobe, dreq.data, dresp.data};

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        fwd_sel #(.NUM_SRC(3)) u_fwd_d (
            .i_src (srcD[i]),
            .i_en  ({weW, weM & ~loadM, weE & ~loadE}),
            .i_dst ({dstW, dstM, dstE}),
            .i_res ({resW, resM, resE}),
            .i_reg (vD[i]),
            .o_fwd (fwdD[i])
        );
        fwd_sel #(.NUM_SRC(2)) u_fwd_e (
            .i_src (srcE[i]),
            .i_en  ({weW, weM & ~loadM}),
            .i_dst ({dstW, dstM}),
            .i_res ({resW, resM}),
            .i_reg (vE[i]),
            .o_fwd (fwdE[i])
        );
    end

`ifdef HAZARD_MDU_EN
    logic [MDU_CNT_W-1:0] r_mdu_cnt;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mdu_cnt <= '0;
        end else if (mdu_start) begin
            r_mdu_cnt <= mdu_div ? MDU_CNT_W'(DIV_LAT) : MDU_CNT_W'(MUL_LAT);
        end else if (r_mdu_cnt != '0) begin
            r_mdu_cnt <= r_mdu_cnt - MDU_CNT_W'(1);
        end
    end

    assign w_hilo_stall = hiloD && (r_mdu_cnt != '0);
`else
    logic w_unused_mdu;
    assign w_unused_mdu = &{1'b0, hiloD, mdu_start, mdu_div};
    assign w_hilo_stall = 1'b0;
`endif

    always_comb begin
        w_data_haz = w_hilo_stall;
        for (int i = 0; i < NUM_RD; i++) begin
            if (loadE && weE && reg_hit(dstE, srcD[i])) w_data_haz = 1'b1;
            if (useD[i] && loadM && weM && reg_hit(dstM, srcD[i])) w_data_haz = 1'b1;
        end
    end

    // The data_ok beat completes the transfer, so it releases the stall that cycle.
    assign w_mem_wait   = ((r_dstate != D_IDLE) || dreq.valid) && !dresp.data_ok;
    assign w_fetch_wait = (ireq.valid && !iresp.data_ok) || (r_istate == I_DROP);
    assign drop_i       = (r_istate == I_DROP) && iresp.data_ok;

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        bubble_e = 1'b0;
        bubble_w = 1'b0;
        if (w_mem_wait) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
        end else begin
            stall_f  = w_data_haz || w_fetch_wait;
            stall_d  = w_data_haz || w_fetch_wait;
            bubble_e = w_data_haz;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_istate <= I_IDLE;
        end else begin
            case (r_istate)
                I_IDLE:  if (ireq.valid && !iresp.data_ok) r_istate <= I_WAIT;
                I_WAIT:  if (iresp.data_ok)                r_istate <= I_IDLE;
                         else if (redirect)                r_istate <= I_DROP;
                I_DROP:  if (iresp.data_ok)                r_istate <= I_IDLE;
                default: r_istate <= I_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dstate <= D_IDLE;
        end else if (dresp.data_ok) begin
            r_dstate <= D_IDLE;
        end else begin
            case (r_dstate)
                D_IDLE:  if (dresp.addr_ok)   r_dstate <= D_DATA;
                         else if (dreq.valid) r_dstate <= D_ADDR;
                D_ADDR:  if (dresp.addr_ok)   r_dstate <= D_DATA;
                D_DATA:  r_dstate <= D_DATA;
                default: r_dstate <= D_IDLE;
            endcase
        end
    end

endmodule
